// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: one radix-2 step per clock, sign fix-up,
// then a single-cycle HI/LO write strobe. Raises Stall while a HI/LO read would be stale.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Flush,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic             HILO_read,
  output logic             Busy,
  output logic             Stall,
  output logic             HILO_we,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out,
  output logic             Div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic             accept;
  logic             is_div_q, neg_main_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q, opb_q;
  logic [CW-1:0]    cnt_q;

  // operand conditioning at issue
  logic             signed_op, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  // one iteration step
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;

  // sign fix-up
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept = Start & ~Flush & ((state == IDLE) | (state == DONE));

  assign signed_op = ~Op[0];
  assign sa        = signed_op & Src_A[WIDTH-1];
  assign sb        = signed_op & Src_B[WIDTH-1];
  assign mag_a     = sa ? (~Src_A + 1'b1) : Src_A;
  assign mag_b     = sb ? (~Src_B + 1'b1) : Src_B;

  // Multiply keeps {hi,lo} = {partial, multiplier}; divide keeps {hi,lo} = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb_q};
    hi_step  = hi_q;
    lo_step  = lo_q;
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        hi_step = div_diff[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = div_sh[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_step, lo_step} = {mul_sum, lo_q[WIDTH-1:1]};
    end
  end

  // Divide by zero naturally leaves |A| in the remainder; negating with the dividend sign restores Src_A.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_main_q ? (~prod + 1'b1) : prod;
    quo_fix  = dz_q ? '1 : (neg_main_q ? (~lo_q + 1'b1) : lo_q);
    rem_fix  = neg_rem_q ? (~hi_q + 1'b1) : hi_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt_q == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      HI_out     <= '0;
      LO_out     <= '0;
    end else if (accept) begin
      is_div_q   <= Op[1];
      neg_main_q <= sa ^ sb;
      neg_rem_q  <= sa;
      dz_q       <= Op[1] & (Src_B == '0);
      hi_q       <= '0;
      lo_q       <= Op[1] ? mag_a : mag_b;
      opb_q      <= Op[1] ? mag_b : mag_a;
      cnt_q      <= CW'(WIDTH - 1);
    end else if (state == RUN) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q - 1'b1;
    end else if (state == FIX) begin
      if (is_div_q) begin
        HI_out <= rem_fix;
        LO_out <= quo_fix;
      end else begin
        {HI_out, LO_out} <= prod_fix;
      end
    end
  end

  assign Busy        = (state == RUN) | (state == FIX);
  assign HILO_we     = (state == DONE);
  assign Div_by_zero = (state == DONE) & dz_q;
  assign Stall       = HILO_read & (Busy | (Start & ~Flush));

endmodule
